// File: rtl/rate_pkg.sv
// rate_pkg: speed encodings and period lookup shared by the rate divider.
package rate_pkg;

    localparam logic [1:0] SPD_FULL    = 2'b00;
    localparam logic [1:0] SPD_1HZ     = 2'b01;
    localparam logic [1:0] SPD_HALF    = 2'b10;
    localparam logic [1:0] SPD_QUARTER = 2'b11;

    // Period minus one; the caller truncates to its counter width.
    function automatic logic [63:0] period_m1(input logic [1:0] spd, input longint unsigned clk_hz);
        return spd == SPD_1HZ     ? clk_hz - 64'd1 :
               spd == SPD_HALF    ? 64'd2 * clk_hz - 64'd1 :
               spd == SPD_QUARTER ? 64'd4 * clk_hz - 64'd1 : 64'd0;
    endfunction

endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchroniser for asynchronous switch inputs.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta_q <= '0;
            q      <= '0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/rate_tick_gen.sv
// rate_tick_gen: programmable divider producing a one-cycle tick at full rate, 1, 0.5 or 0.25 Hz.
module rate_tick_gen
    import rate_pkg::*;
#(
    parameter longint unsigned CLK_HZ = 50_000_000,
    parameter int              CNT_W  = 28
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [1:0] speed,
    input  logic       run,
    input  logic       clear,
    output logic       tick,
    output logic [1:0] speed_q
);

    logic [1:0]       speed_s, speed_d;
    logic             run_s, tick_q, tick_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, reload_cur, reload_new;

    sync2 #(.W(3)) u_sync (
        .clk    (CLOCK_50),
        .resetn (resetn),
        .d      ({speed, run}),
        .q      ({speed_s, run_s})
    );

    assign reload_cur = CNT_W'(period_m1(speed_q, CLK_HZ));
    assign reload_new = CNT_W'(period_m1(speed_s, CLK_HZ));
    assign tick       = tick_q;

    // A clear or speed change swallows any tick due on the same edge.
    always_comb begin
        cnt_d   = cnt_q;
        speed_d = speed_q;
        tick_d  = 1'b0;
        if (clear) begin
            cnt_d = reload_cur;
        end else if (speed_s != speed_q) begin
            speed_d = speed_s;
            cnt_d   = reload_new;
        end else if (run_s) begin
            tick_d = cnt_q == '0;
            cnt_d  = cnt_q == '0 ? reload_cur : cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            cnt_q   <= '0;
            speed_q <= SPD_FULL;
            tick_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            speed_q <= speed_d;
            tick_q  <= tick_d;
        end
    end

endmodule

// File: tb/tb_rate_tick_gen.sv
// tb_rate_tick_gen: directed checks of the rate divider at CLK_HZ=4 (P = 1/4/8/16).
module tb_rate_tick_gen;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       run = 1'b0;
    logic       clear = 1'b0;
    logic [1:0] speed = 2'b00;
    logic       tick;
    logic [1:0] speed_q;
    int         errors = 0;
    int         checks = 0;
    int         n = 0;

    always #5 clk = ~clk;

    rate_tick_gen #(.CLK_HZ(4), .CNT_W(8)) dut (
        .CLOCK_50 (clk),
        .resetn   (resetn),
        .speed    (speed),
        .run      (run),
        .clear    (clear),
        .tick     (tick),
        .speed_q  (speed_q)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        n++;
    endtask

    task automatic do_reset(input logic [1:0] s, input logic r);
        resetn = 1'b0;
        speed  = s;
        run    = r;
        clear  = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        n      = 0;
    endtask

    task automatic test_reset();
        do_reset(2'b01, 1'b1);
        repeat (7) step();
        checks++;
        if (tick !== 1'b1) begin errors++; $display("FAIL reset_pre_tick n=%0d tick=%0b exp=1", n, tick); end
        #1 resetn = 1'b0;
        #1;
        checks++;
        if (tick !== 1'b0) begin errors++; $display("FAIL reset_async_tick tick=%0b exp=0", tick); end
        checks++;
        if (speed_q !== 2'b00) begin errors++; $display("FAIL reset_async_speed speed_q=%0b exp=00", speed_q); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (tick !== 1'b0 || speed_q !== 2'b00) begin
                errors++; $display("FAIL reset_hold i=%0d tick=%0b speed_q=%0b exp=0/00", i, tick, speed_q);
            end
        end
    endtask

    task automatic test_1hz();
        logic exp;
        do_reset(2'b01, 1'b1);
        for (int i = 0; i < 40; i++) begin
            step();
            exp = n >= 7 && (n - 7) % 4 == 0;
            checks++;
            if (tick !== exp) begin errors++; $display("FAIL rate_1hz n=%0d tick=%0b exp=%0b", n, tick, exp); end
            if (n == 2 || n == 3) begin
                checks++;
                if (speed_q !== (n == 2 ? 2'b00 : 2'b01)) begin
                    errors++; $display("FAIL rate_1hz_speed n=%0d speed_q=%0b", n, speed_q);
                end
            end
        end
    endtask

    task automatic test_full_rate();
        logic exp;
        do_reset(2'b00, 1'b1);
        for (int i = 0; i < 12; i++) begin
            if (n == 8) run = 1'b0;
            step();
            exp = n >= 3 && n <= 10;
            checks++;
            if (tick !== exp) begin errors++; $display("FAIL full_rate n=%0d tick=%0b exp=%0b", n, tick, exp); end
        end
    endtask

    task automatic test_speed_change();
        logic exp;
        do_reset(2'b01, 1'b1);
        for (int i = 0; i < 60; i++) begin
            if (n == 8) speed = 2'b11;
            step();
            exp = n == 7 || n == 27 || n == 43 || n == 59;
            checks++;
            if (tick !== exp) begin errors++; $display("FAIL speed_change n=%0d tick=%0b exp=%0b", n, tick, exp); end
            if (n == 10 || n == 11) begin
                checks++;
                if (speed_q !== (n == 10 ? 2'b01 : 2'b11)) begin
                    errors++; $display("FAIL speed_change_q n=%0d speed_q=%0b", n, speed_q);
                end
            end
        end
    endtask

    task automatic test_pause();
        logic exp;
        do_reset(2'b10, 1'b1);
        for (int i = 0; i < 30; i++) begin
            if (n == 3) run = 1'b0;
            if (n == 13) run = 1'b1;
            step();
            exp = n == 21 || n == 29;
            checks++;
            if (tick !== exp) begin errors++; $display("FAIL pause n=%0d tick=%0b exp=%0b", n, tick, exp); end
        end
    endtask

    task automatic test_clear_collision();
        logic exp;
        do_reset(2'b01, 1'b1);
        for (int i = 0; i < 20; i++) begin
            clear = n == 10;
            step();
            exp = n == 7 || n == 15 || n == 19;
            checks++;
            if (tick !== exp) begin errors++; $display("FAIL clear_collision n=%0d tick=%0b exp=%0b", n, tick, exp); end
        end
        clear = 1'b0;
    endtask

    initial begin
        test_reset();
        test_1hz();
        test_full_rate();
        test_speed_change();
        test_pause();
        test_clear_collision();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
